// File: rtl/mem_pkg.sv
// Shared encodings and request-shaping helpers for the data-memory initiator
// and any slave-side model that must decode the same load/store types.
package mem_pkg;

  localparam logic [1:0] ST_W = 2'd0;
  localparam logic [1:0] ST_H = 2'd1;
  localparam logic [1:0] ST_B = 2'd2;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_HU = 3'd2;
  localparam logic [2:0] LD_B  = 3'd3;
  localparam logic [2:0] LD_BU = 3'd4;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } lsu_state_e;

  // Unlisted encodings (StoreType 3, LoadType 5-7) fall back to word access.
  function automatic logic access_aligned(input logic we, input logic [1:0] st,
                                          input logic [2:0] lt, input logic [1:0] off);
    logic ok;
    ok = (off == 2'b00);
    if (we) begin
      if (st == ST_H) ok = ~off[0];
      else if (st == ST_B) ok = 1'b1;
    end else begin
      if (lt == LD_H || lt == LD_HU) ok = ~off[0];
      else if (lt == LD_B || lt == LD_BU) ok = 1'b1;
    end
    return ok;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] st, input logic [1:0] off);
    logic [3:0] be;
    be = BE_WORD;
    if (st == ST_H) be = off[1] ? BE_HALF_HI : BE_HALF_LO;
    else if (st == ST_B) be = BE_BYTE0 << off;
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] st, input logic [31:0] wd);
    logic [31:0] d;
    d = wd;
    if (st == ST_H) d = {2{wd[15:0]}};
    else if (st == ST_B) d = {4{wd[7:0]}};
    return d;
  endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Extracts and extends the addressed halfword/byte of a bus read word.
// Purely combinational so the slave-side model can reuse it.
module lsu_load_fmt
  import mem_pkg::*;
(
  input  logic [31:0] bus_rdata,
  input  logic [2:0]  load_type,
  input  logic [1:0]  byte_off,
  output logic [31:0] rdata
);

  logic [15:0] half;
  logic [7:0]  sel_byte;

  always_comb begin
    half     = byte_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    sel_byte = bus_rdata[7:0];
    case (byte_off)
      2'd1:    sel_byte = bus_rdata[15:8];
      2'd2:    sel_byte = bus_rdata[23:16];
      2'd3:    sel_byte = bus_rdata[31:24];
      default: sel_byte = bus_rdata[7:0];
    endcase
  end

  always_comb begin
    rdata = bus_rdata;
    case (load_type)
      LD_H:    rdata = {{16{half[15]}}, half};
      LD_HU:   rdata = {16'd0, half};
      LD_B:    rdata = {{24{sel_byte[7]}}, sel_byte};
      LD_BU:   rdata = {24'd0, sel_byte};
      default: rdata = bus_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// MEM-stage bus initiator: turns pipeline load/store requests into a
// req/ack bus transaction, stalls until it completes, and formats loads.
module lsu_bus_master
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        MemWr,
  input  logic [1:0]  StoreType,
  input  logic [2:0]  LoadType,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] PC_M,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misalign,
  output logic        bus_err,
  output logic [31:0] bad_pc,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  // wait_cnt counts REQ cycles already spent without ack; the abort fires in
  // the TIMEOUT-th such cycle so bus_req is high for exactly TIMEOUT cycles.
  localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : TIMEOUT - 1;

  lsu_state_e  state, state_next;
  logic        op_we;
  logic [2:0]  op_lt;
  logic [31:0] op_addr, op_wdata, op_pc;
  logic [3:0]  op_be;
  logic [31:0] wait_cnt;
  logic [31:0] fmt_data;
  logic        aligned, accept, reject, timeout_hit, abort;

  assign aligned     = access_aligned(MemWr, StoreType, LoadType, addr[1:0]);
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == TO_LAST);
  assign abort       = (state == S_REQ) && !bus_ack && timeout_hit;

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    bus_req    = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_valid) begin
          if (aligned) begin
            accept     = 1'b1;
            stall      = 1'b1;
            state_next = S_REQ;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_REQ: begin
        stall   = 1'b1;
        bus_req = 1'b1;
        if (bus_ack || timeout_hit) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Request fields are only driven while a request is outstanding.
  assign bus_we    = bus_req & op_we;
  assign bus_addr  = bus_req ? {op_addr[31:2], 2'b00} : 32'd0;
  assign bus_be    = bus_req ? op_be : 4'd0;
  assign bus_wdata = bus_req ? op_wdata : 32'd0;

  lsu_load_fmt u_fmt (
    .bus_rdata (bus_rdata),
    .load_type (op_lt),
    .byte_off  (op_addr[1:0]),
    .rdata     (fmt_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_we    <= 1'b0;
      op_lt    <= LD_W;
      op_addr  <= 32'd0;
      op_wdata <= 32'd0;
      op_be    <= 4'd0;
      op_pc    <= 32'd0;
      wait_cnt <= 32'd0;
    end else begin
      if (accept) begin
        op_we    <= MemWr;
        op_lt    <= LoadType;
        op_addr  <= addr;
        op_wdata <= MemWr ? store_data(StoreType, wdata) : 32'd0;
        op_be    <= MemWr ? store_be(StoreType, addr[1:0]) : BE_WORD;
        op_pc    <= PC_M;
      end
      if (state == S_REQ && !bus_ack) wait_cnt <= wait_cnt + 32'd1;
      else                            wait_cnt <= 32'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata       <= 32'd0;
      rdata_valid <= 1'b0;
      misalign    <= 1'b0;
      bus_err     <= 1'b0;
      bad_pc      <= 32'd0;
    end else begin
      rdata_valid <= (state == S_REQ) && bus_ack && !op_we;
      misalign    <= reject;
      bus_err     <= abort;
      if ((state == S_REQ) && bus_ack && !op_we) rdata <= fmt_data;
      if (reject)     bad_pc <= PC_M;
      else if (abort) bad_pc <= op_pc;
    end
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Scoreboard bench for lsu_bus_master: directed ops push expected bus/result
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_lsu_bus_master;

  typedef enum {EV_BUS, EV_RDATA, EV_MISALIGN, EV_BUSERR} ev_kind_e;
  typedef enum {OUT_OK, OUT_MIS, OUT_TO} outcome_e;
  typedef struct {
    ev_kind_e    kind;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        we;
  } exp_t;

  exp_t exp_q[$];
  int check_count = 0;
  int pass_count  = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        use_to = 1'b0;
  logic        mem_valid = 1'b0;
  logic        MemWr = 1'b0;
  logic [1:0]  StoreType = 2'd0;
  logic [2:0]  LoadType = 3'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0, PC_M = 32'd0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  logic        m_stall, m_rdata_valid, m_misalign, m_bus_err, m_bus_req, m_bus_we;
  logic [31:0] m_rdata, m_bad_pc, m_bus_addr, m_bus_wdata;
  logic [3:0]  m_bus_be;
  logic        t_stall, t_rdata_valid, t_misalign, t_bus_err, t_bus_req, t_bus_we;
  logic [31:0] t_rdata, t_bad_pc, t_bus_addr, t_bus_wdata;
  logic [3:0]  t_bus_be;

  logic        s_stall, s_rdata_valid, s_misalign, s_bus_err, s_bus_req, s_bus_we;
  logic [31:0] s_rdata, s_bad_pc, s_bus_addr, s_bus_wdata;
  logic [3:0]  s_bus_be;

  always #5 clk = ~clk;

  lsu_bus_master dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid & ~use_to), .MemWr(MemWr),
    .StoreType(StoreType), .LoadType(LoadType), .addr(addr), .wdata(wdata), .PC_M(PC_M),
    .stall(m_stall), .rdata(m_rdata), .rdata_valid(m_rdata_valid), .misalign(m_misalign),
    .bus_err(m_bus_err), .bad_pc(m_bad_pc), .bus_req(m_bus_req), .bus_we(m_bus_we),
    .bus_addr(m_bus_addr), .bus_be(m_bus_be), .bus_wdata(m_bus_wdata),
    .bus_ack(bus_ack & ~use_to), .bus_rdata(bus_rdata)
  );

  lsu_bus_master #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .mem_valid(mem_valid & use_to), .MemWr(MemWr),
    .StoreType(StoreType), .LoadType(LoadType), .addr(addr), .wdata(wdata), .PC_M(PC_M),
    .stall(t_stall), .rdata(t_rdata), .rdata_valid(t_rdata_valid), .misalign(t_misalign),
    .bus_err(t_bus_err), .bad_pc(t_bad_pc), .bus_req(t_bus_req), .bus_we(t_bus_we),
    .bus_addr(t_bus_addr), .bus_be(t_bus_be), .bus_wdata(t_bus_wdata),
    .bus_ack(bus_ack & use_to), .bus_rdata(bus_rdata)
  );

  assign s_stall       = use_to ? t_stall       : m_stall;
  assign s_rdata       = use_to ? t_rdata       : m_rdata;
  assign s_rdata_valid = use_to ? t_rdata_valid : m_rdata_valid;
  assign s_misalign    = use_to ? t_misalign    : m_misalign;
  assign s_bus_err     = use_to ? t_bus_err     : m_bus_err;
  assign s_bad_pc      = use_to ? t_bad_pc      : m_bad_pc;
  assign s_bus_req     = use_to ? t_bus_req     : m_bus_req;
  assign s_bus_we      = use_to ? t_bus_we      : m_bus_we;
  assign s_bus_addr    = use_to ? t_bus_addr    : m_bus_addr;
  assign s_bus_be      = use_to ? t_bus_be      : m_bus_be;
  assign s_bus_wdata   = use_to ? t_bus_wdata   : m_bus_wdata;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    check_count++;
    if (act === expv) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
  endtask

  task automatic popExpect(input ev_kind_e k, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '{kind: EV_BUS, a: 32'd0, d: 32'd0, be: 4'd0, we: 1'b0};
    if (exp_q.size() == 0) begin
      check_count++;
      $display("[TB] FAIL unexpected_event: got %s expected none", k.name());
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k) begin
        check_count++;
        $display("[TB] FAIL event_order: got %s expected %s", k.name(), e.kind.name());
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  // Monitor: every DUT-presented event must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (!rst) begin
      if (s_bus_req && bus_ack) begin
        popExpect(EV_BUS, e, ok);
        if (ok) begin
          checkOutput("bus_addr", s_bus_addr, e.a);
          checkOutput("bus_be", {28'd0, s_bus_be}, {28'd0, e.be});
          checkOutput("bus_we", {31'd0, s_bus_we}, {31'd0, e.we});
          if (e.we) checkOutput("bus_wdata", s_bus_wdata, e.d);
        end
      end
      if (s_rdata_valid) begin
        popExpect(EV_RDATA, e, ok);
        if (ok) checkOutput("rdata", s_rdata, e.d);
      end
      if (s_misalign) begin
        popExpect(EV_MISALIGN, e, ok);
        if (ok) checkOutput("misalign_bad_pc", s_bad_pc, e.a);
      end
      if (s_bus_err) begin
        popExpect(EV_BUSERR, e, ok);
        if (ok) begin
          checkOutput("bus_err_bad_pc", s_bad_pc, e.a);
          checkOutput("bus_err_rdata_kept", s_rdata, e.d);
        end
      end
    end
  end

  // waits < 0 means the slave never acks.
  task automatic applyStimulus(input string name, input outcome_e oc, input logic we,
                               input logic [1:0] st, input logic [2:0] lt,
                               input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc,
                               input int waits, input logic [31:0] rword,
                               input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                               input logic [31:0] exp_rdata, input int exp_stall, input int exp_req);
    int stall_cnt = 0;
    int req_cnt   = 0;
    bit done      = 1'b0;
    bit stable    = 1'b1;
    case (oc)
      OUT_OK: begin
        exp_q.push_back('{kind: EV_BUS, a: {a[31:2], 2'b00}, d: exp_wdata, be: exp_be, we: we});
        if (!we) exp_q.push_back('{kind: EV_RDATA, a: 32'd0, d: exp_rdata, be: 4'd0, we: 1'b0});
      end
      OUT_MIS: exp_q.push_back('{kind: EV_MISALIGN, a: pc, d: 32'd0, be: 4'd0, we: 1'b0});
      default: exp_q.push_back('{kind: EV_BUSERR, a: pc, d: exp_rdata, be: 4'd0, we: 1'b0});
    endcase
    MemWr = we; StoreType = st; LoadType = lt; addr = a; wdata = wd; PC_M = pc;
    bus_rdata = rword;
    mem_valid = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      bus_ack = (waits >= 0) && (c == waits + 1);
      @(negedge clk);
      if (s_stall) stall_cnt++;
      else done = 1'b1;
      if (s_bus_req) begin
        req_cnt++;
        if (s_bus_addr !== {a[31:2], 2'b00} || s_bus_be !== exp_be || s_bus_we !== we ||
            (we && s_bus_wdata !== exp_wdata))
          stable = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    mem_valid = 1'b0;
    bus_ack   = 1'b0;
    checkOutput({name, "_completed"}, {31'd0, done}, 32'd1);
    checkOutput({name, "_stall_cycles"}, stall_cnt, exp_stall);
    checkOutput({name, "_req_cycles"}, req_cnt, exp_req);
    if (exp_req > 0) checkOutput({name, "_req_stable"}, {31'd0, stable}, 32'd1);
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_stall"}, {31'd0, s_stall}, 32'd0);
    checkOutput({name, "_bus_req"}, {31'd0, s_bus_req}, 32'd0);
    checkOutput({name, "_bus_we"}, {31'd0, s_bus_we}, 32'd0);
    checkOutput({name, "_bus_addr"}, s_bus_addr, 32'd0);
    checkOutput({name, "_bus_be"}, {28'd0, s_bus_be}, 32'd0);
    checkOutput({name, "_bus_wdata"}, s_bus_wdata, 32'd0);
    checkOutput({name, "_rdata"}, s_rdata, 32'd0);
    checkOutput({name, "_flags"}, {29'd0, s_rdata_valid, s_misalign, s_bus_err}, 32'd0);
    checkOutput({name, "_bad_pc"}, s_bad_pc, 32'd0);
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting lsu_bus_master bench");
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    checkOutput("reset_to_bus_req", {31'd0, t_bus_req}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus("sw", OUT_OK, 1'b1, 2'd0, 3'd0, 32'h10, 32'hDEADBEEF, 32'h00400000,
                  0, 32'h0, 4'b1111, 32'hDEADBEEF, 32'h0, 2, 1);
    applyStimulus("sb_wait4", OUT_OK, 1'b1, 2'd2, 3'd0, 32'h13, 32'h000000A5, 32'h00400004,
                  4, 32'h0, 4'b1000, 32'hA5A5A5A5, 32'h0, 6, 5);
    applyStimulus("sh_hi", OUT_OK, 1'b1, 2'd1, 3'd0, 32'h12, 32'h1234ABCD, 32'h00400008,
                  1, 32'h0, 4'b1100, 32'hABCDABCD, 32'h0, 3, 2);
    applyStimulus("sw_type3", OUT_OK, 1'b1, 2'd3, 3'd0, 32'h18, 32'h01020304, 32'h0040000C,
                  0, 32'h0, 4'b1111, 32'h01020304, 32'h0, 2, 1);
    applyStimulus("lb", OUT_OK, 1'b0, 2'd0, 3'd3, 32'h21, 32'h0, 32'h00400010,
                  0, 32'h1234F0AA, 4'b1111, 32'h0, 32'hFFFFFFF0, 2, 1);
    applyStimulus("lbu", OUT_OK, 1'b0, 2'd0, 3'd4, 32'h21, 32'h0, 32'h00400014,
                  2, 32'h1234F0AA, 4'b1111, 32'h0, 32'h000000F0, 4, 3);
    applyStimulus("lh", OUT_OK, 1'b0, 2'd0, 3'd1, 32'h22, 32'h0, 32'h00400018,
                  0, 32'h80007FFF, 4'b1111, 32'h0, 32'hFFFF8000, 2, 1);
    applyStimulus("lhu", OUT_OK, 1'b0, 2'd0, 3'd2, 32'h20, 32'h0, 32'h0040001C,
                  0, 32'h80007FFF, 4'b1111, 32'h0, 32'h00007FFF, 2, 1);
    applyStimulus("lw", OUT_OK, 1'b0, 2'd0, 3'd0, 32'h40, 32'h0, 32'h00400020,
                  1, 32'hCAFEF00D, 4'b1111, 32'h0, 32'hCAFEF00D, 3, 2);
    applyStimulus("lw_misalign", OUT_MIS, 1'b0, 2'd0, 3'd0, 32'h06, 32'h0, 32'h00400020,
                  -1, 32'h0, 4'b1111, 32'h0, 32'h0, 0, 0);
    applyStimulus("sh_misalign", OUT_MIS, 1'b1, 2'd1, 3'd0, 32'h11, 32'h0, 32'h00400024,
                  -1, 32'h0, 4'b1111, 32'h0, 32'h0, 0, 0);
    @(posedge clk);
    #1;
    checkOutput("bad_pc_held", s_bad_pc, 32'h00400024);
    checkOutput("rdata_held", s_rdata, 32'hCAFEF00D);

    use_to = 1'b1;
    applyStimulus("lw_timeout", OUT_TO, 1'b0, 2'd0, 3'd0, 32'h80, 32'h0, 32'h00400100,
                  -1, 32'h0, 4'b1111, 32'h0, 32'h0, 5, 4);
    applyStimulus("lw_after_to", OUT_OK, 1'b0, 2'd0, 3'd0, 32'h84, 32'h0, 32'h00400104,
                  0, 32'h11223344, 4'b1111, 32'h0, 32'h11223344, 2, 1);
    applyStimulus("lw_ack_at_limit", OUT_OK, 1'b0, 2'd0, 3'd5, 32'h88, 32'h0, 32'h00400108,
                  3, 32'h55667788, 4'b1111, 32'h0, 32'h55667788, 5, 4);
    checkOutput("to_bad_pc_held", s_bad_pc, 32'h00400100);
    use_to = 1'b0;

    MemWr = 1'b0; LoadType = 3'd0; addr = 32'h90; PC_M = 32'h00400200;
    bus_ack = 1'b0;
    mem_valid = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    checkOutput("req_before_reset", {31'd0, s_bus_req}, 32'd1);
    rst = 1'b1;
    mem_valid = 1'b0;
    #1;
    checkOutput("async_reset_bus_req", {31'd0, s_bus_req}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkResetOutputs("after_reset");
    @(posedge clk);
    #1;
    applyStimulus("sw_recover", OUT_OK, 1'b1, 2'd0, 3'd0, 32'h14, 32'h0BADF00D, 32'h00400300,
                  0, 32'h0, 4'b1111, 32'h0BADF00D, 32'h0, 2, 1);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
